// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 single-bit mux with a per-owner burst limit.
// The grant and selects are registered; y is the selected input qualified by valid.
module rr_mux4_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       valid,
    output logic       y
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD = 4'(HOLD_MAX);

    state_t     state, state_nx;
    logic [1:0] owner, owner_nx;
    logic [1:0] last, last_nx;
    logic [3:0] cnt, cnt_nx;
    logic [3:0] gnt_nx;
    logic [3:0] owner_oh;
    logic       others;
    logic [2:0] idle_pick;
    logic [2:0] sw_pick;

    // Returns {found, index}; scans from+1 .. from+4 (mod 4), optionally skipping 'from'.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] from,
                                        input logic skip_from);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = from + 2'(i);
            if (!found && r[cand] && !(skip_from && cand == from)) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign owner_oh  = 4'b0001 << owner;
    assign others    = |(req & ~owner_oh);
    assign idle_pick = pick(req, last, 1'b0);
    assign sw_pick   = pick(req, owner, 1'b1);

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (idle_pick[2]) begin
                    state_nx = GRANT;
                    owner_nx = idle_pick[1:0];
                    last_nx  = idle_pick[1:0];
                    cnt_nx   = 4'd1;
                end
            end
            GRANT: begin
                if (req[owner] && (cnt < HOLD || !others)) begin
                    if (cnt < HOLD) cnt_nx = cnt + 4'd1;
                end else if (sw_pick[2]) begin
                    owner_nx = sw_pick[1:0];
                    last_nx  = sw_pick[1:0];
                    cnt_nx   = 4'd1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        gnt_nx = (state_nx == GRANT) ? (4'b0001 << owner_nx) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            last  <= 2'd3;
            cnt   <= '0;
            gnt   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
            gnt   <= gnt_nx;
            valid <= (state_nx == GRANT);
        end
    end

    // owner only changes on a grant, so the selects hold their value through IDLE.
    assign {s1, s0} = owner;

    always_comb begin
        y = 1'b0;
        unique case ({s1, s0})
            2'b00: y = a;
            2'b01: y = b;
            2'b10: y = c;
            2'b11: y = d;
            default: y = 1'b0;
        endcase
        y = y & valid;
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Randomized and directed bench for rr_mux4_arbiter against a behavioural arbitration model.
module tb_rr_mux4_arbiter;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'hF;
    logic       a = 1'b1, b = 1'b1, c = 1'b1, d = 1'b1;
    logic [3:0] gnt;
    logic       s1, s0, valid, y;

    int checks = 0;
    int errors = 0;

    rr_mux4_arbiter #(.HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt), .s1(s1), .s0(s0), .valid(valid), .y(y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: ownership, last winner, burst count
    int m_owner = 0, m_last = 3, m_cnt = 0;
    bit m_busy = 1'b0;

    function automatic int search(input logic [3:0] r, input int from, input bit skip);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (from + k) % 4;
            if (r[idx] && !(skip && idx == from)) return idx;
        end
        return -1;
    endfunction

    function automatic bit others_pending(input logic [3:0] r, input int own);
        for (int k = 0; k < 4; k++)
            if (k != own && r[k]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_last  <= 3;
            m_cnt   <= 0;
        end else if (!m_busy) begin
            if (req != 4'b0000) begin
                m_busy  <= 1'b1;
                m_owner <= search(req, m_last, 1'b0);
                m_last  <= search(req, m_last, 1'b0);
                m_cnt   <= 1;
            end
        end else if (req[m_owner] && (m_cnt < HM || !others_pending(req, m_owner))) begin
            m_cnt <= (m_cnt + 1 > HM) ? HM : m_cnt + 1;
        end else if (others_pending(req, m_owner)) begin
            m_owner <= search(req, m_owner, 1'b1);
            m_last  <= search(req, m_owner, 1'b1);
            m_cnt   <= 1;
        end else begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [3:0] din;
            logic [3:0] g_exp;
            logic       y_exp;
            din   = {d, c, b, a};
            g_exp = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            y_exp = m_busy ? din[m_owner] : 1'b0;
            check("model_gnt", {4'b0, gnt}, {4'b0, g_exp});
            check("model_sel", {6'b0, s1, s0}, 8'(m_owner));
            check("model_valid", {7'b0, valid}, {7'b0, m_busy});
            check("model_y", {7'b0, y}, {7'b0, y_exp});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] r);
        @(posedge clk);
        #2 rst = 1'b1;
        req = r;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rst_pending;
        // Reset held with full request vector
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {4'b0, gnt}, 8'h00);
        check("rst_sel", {6'b0, s1, s0}, 8'h00);
        check("rst_valid", {7'b0, valid}, 8'h00);
        check("rst_y", {7'b0, y}, 8'h00);
        @(posedge clk);
        #2 rst = 1'b0;
        a = 1'b0; b = 1'b1; c = 1'b1; d = 1'b0;

        // Full contention rotation
        for (int n = 0; n < 24; n++) begin
            int own;
            next_cycle();
            own = (n / 4) % 4;
            check("rot_gnt", {4'b0, gnt}, 8'(4'b0001 << own));
            check("rot_y", {7'b0, y}, (own == 1 || own == 2) ? 8'h01 : 8'h00);
        end

        // Async reset mid-burst while gnt = 0010
        #1 rst = 1'b1;
        #1;
        check("arst_gnt", {4'b0, gnt}, 8'h00);
        check("arst_valid", {7'b0, valid}, 8'h00);
        check("arst_y", {7'b0, y}, 8'h00);
        req = 4'b0010;
        @(posedge clk);
        #2 rst = 1'b0;
        next_cycle();
        check("arst_resume", {4'b0, gnt}, 8'h02);

        // Early drop of owner 0 hands over to 2 without a bubble
        do_reset(4'b0101);
        next_cycle();
        check("drop_g1", {4'b0, gnt}, 8'h01);
        next_cycle();
        check("drop_g2", {4'b0, gnt}, 8'h01);
        #1 req = 4'b0100;
        next_cycle();
        check("drop_gnt", {4'b0, gnt}, 8'h04);
        check("drop_sel", {6'b0, s1, s0}, 8'h02);
        check("drop_valid", {7'b0, valid}, 8'h01);

        // Idle, then resume with fairness from last=2
        #1 req = 4'b0000;
        next_cycle();
        check("idle_gnt", {4'b0, gnt}, 8'h00);
        check("idle_valid", {7'b0, valid}, 8'h00);
        check("idle_y", {7'b0, y}, 8'h00);
        check("idle_sel_hold", {6'b0, s1, s0}, 8'h02);
        #1 req = 4'b0011;
        next_cycle();
        check("resume_gnt", {4'b0, gnt}, 8'h01);
        check("resume_sel", {6'b0, s1, s0}, 8'h00);

        // Lone requester never releases
        do_reset(4'b0100);
        c = 1'b1;
        for (int n = 0; n < 10; n++) begin
            next_cycle();
            check("single_gnt", {4'b0, gnt}, 8'h04);
            check("single_sel", {6'b0, s1, s0}, 8'h02);
            check("single_y", {7'b0, y}, 8'h01);
        end

        // Randomized traffic with occasional async resets
        rst_pending = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #2;
            if (rst_pending) begin
                rst = 1'b0;
                rst_pending = 1'b0;
            end
            if ($urandom_range(0, 9) < 4) req = 4'hF;
            else req = 4'($urandom);
            a = 1'($urandom); b = 1'($urandom);
            c = 1'($urandom); d = 1'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                rst_pending = 1'b1;
                #1;
                check("rand_arst_gnt", {4'b0, gnt}, 8'h00);
                check("rand_arst_valid", {7'b0, valid}, 8'h00);
            end
        end
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux4_arbiter.md
# rr_mux4_arbiter

Round-robin arbiter and select sequencer for the 4:1 single-bit data multiplexer. Four requesters compete for the shared mux output. The block grants one requester at a time and drives the mux selects `s1`/`s0` from a registered owner index. It bounds each grant with a burst limit so no requester can starve the others, and presents the selected input on `y` qualified by `valid`.

## Interface
Parameters:
- `HOLD_MAX`, default 4: maximum consecutive cycles one owner keeps the grant while another requester is waiting. Legal range is 1..15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 4: request vector; bit i belongs to requester i.
- `a`, `b`, `c`, `d` input 1 each: mux data inputs for requesters 0, 1, 2, 3.
- `gnt` output 4: one-hot grant, registered; all zeros when idle.
- `s1`, `s0` output 1 each: registered mux selects; {s1,s0} = owner index.
- `valid` output 1: registered; high exactly when `gnt` is nonzero.
- `y` output 1: combinational; selected data input when `valid`=1, otherwise 0.

## Operation
- State: FSM {IDLE, GRANT}; `owner[1:0]`; `last[1:0]` (last granted index); `cnt` (4 bits, burst count).
- Winner search: scan indices (last+1), (last+2), (last+3), (last+4) mod 4. The first index whose `req` bit is set wins.
- IDLE:
  - If `req`=0000, stay in IDLE.
  - Otherwise, on the next edge: GRANT, owner=winner, last=winner, cnt=1.
- GRANT, evaluated every edge using the current `req`:
  - Keep: `req[owner]`=1 and (cnt<HOLD_MAX or no other req bit set). Owner is unchanged; cnt increments and saturates at HOLD_MAX.
  - Release: `req[owner]`=0, or (cnt==HOLD_MAX and any other req bit set).
    - If any non-owner request is pending, switch to the winner (search from last=owner, owner excluded). Set cnt=1 on the same edge. No idle bubble.
    - Otherwise, go to IDLE with `gnt`=0000.
- Outputs:
  - `gnt` = one-hot(owner) in GRANT, 0000 in IDLE.
  - {s1,s0} = owner in GRANT; they hold their last value in IDLE.
  - `valid` = (state==GRANT).
- `y` mux mapping: sel 00→a, 01→b, 10→c, 11→d, AND `valid`.
- `last` persists through IDLE, so fairness continues across idle periods.

## Timing
- Reset (async assert, sync-safe release):
  - state=IDLE, `gnt`=0000, `s1`=`s0`=0, `valid`=0, `y`=0, cnt=0.
  - last=3, so requester 0 has first priority after reset.
- Grant latency: `req` sampled high at edge k gives `gnt`/`valid`/selects updated after edge k; `y` is valid in that same cycle.
- Handoff latency: 1 edge. The old grant drops and the new grant asserts on the same edge.
- Requester 0 → 1 mapping: a request that drops is reflected in `gnt` after the next edge. Requesters must tolerate one extra granted cycle after deasserting.
- Under full contention, each requester receives exactly HOLD_MAX consecutive cycles per rotation of 4×HOLD_MAX cycles.
- With HOLD_MAX=1, the grant rotates every cycle under full contention.
- Reset mid-grant: outputs go to reset values immediately, without waiting for `clk`. Arbitration restarts from requester 0.
- Changing `req` mid-cycle has no effect until the next edge; there is no combinational path from `req` to any output.

## Test plan
- Reset: hold `rst`=1 with `req`=1111 → `gnt`=0000, `s1s0`=00, `valid`=0, `y`=0. After release and one edge → `gnt`=0001.
- Single requester: `req`=0100, c=1, held for 10 cycles (HOLD_MAX=4) → from edge 1, `gnt`=0100, s1s0=10, `y`=1 continuously. No release occurs, since no contention.
- Full contention: `req`=1111 from reset, HOLD_MAX=4 → `gnt` is 0001 ×4, 0010 ×4, 0100 ×4, 1000 ×4, then 0001 again. Check `y` tracks a/b/c/d with a=0, b=1, c=1, d=0.
- Early drop: owner 0, `req`=0101; drop `req[0]` after 2 granted cycles → the next edge gives `gnt`=0100, s1s0=10, with no cycle of `valid`=0.
- Idle and resume: last owner 2, all req drop → next edge `gnt`=0000, `valid`=0, `y`=0. Then `req`=0011 → `gnt`=0001 (search starts at 3, then 0).
- Async reset mid-burst: assert `rst` between edges while `gnt`=0010 → `gnt`, `valid`, `y` go to 0 immediately. After release with `req`=0010 → `gnt`=0010 after one edge.
